cluster_mean_divider: RTL and testbench

- Iterative radix-2 restoring unsigned divider for the k-means cluster-mean stage: coordinate sum / member count.
- Parametrised in operand widths.
- Adds a valid/ready handshake on both sides, remainder output, optional round-to-nearest, divide-by-zero flag, and a global enable that freezes state.
- Sits between the cluster accumulators and the centroid register update.

---
 rtl/cluster_mean_divider.sv | 123 ++++++++++++
 tb/tb_cluster_mean_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cluster_mean_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cluster_mean_divider: iterative restoring divider (sum / count) with    |
// | valid/ready on both sides, optional round-half-up. Rev 1.0              |
// +------------------------------------------------------------------------+
module cluster_mean_divider #(
    parameter int DIVIDEND_W = 20,
    parameter int DIVISOR_W  = 12,
    parameter int ROUND      = 0
) (
    input  logic                  clk,
    input  logic                  sclr,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                c_CNT_W = $clog2(DIVIDEND_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIVIDEND_W - 1);
    localparam logic              c_ROUND = (ROUND != 0);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;      // dividend shifts out MSB-first, quotient shifts in LSB
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W:0]    r_prem;
    logic                  r_out_valid;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dz;

    logic [DIVISOR_W+1:0]  w_shift;
    logic                  w_ge;
    logic [DIVISOR_W:0]    w_sub;
    logic                  w_round;
    logic [DIVIDEND_W-1:0] w_inc;

    // Partial remainder stays below the divisor, so the difference fits in DIVISOR_W+1 bits.
    assign w_shift = {r_prem, r_dvd[DIVIDEND_W-1]};
    assign w_ge    = (w_shift >= {2'b00, r_dvs});
    assign w_sub   = w_shift[DIVISOR_W:0] - {1'b0, r_dvs};
    assign w_round = c_ROUND && ({r_prem, 1'b0} >= {2'b00, r_dvs});
    assign w_inc   = {{(DIVIDEND_W-1){1'b0}}, w_round};

    assign in_ready    = en && (r_state == c_IDLE);
    assign out_valid   = r_out_valid;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_out_valid <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
        end else if (en) begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
                        r_prem <= '0;
                        r_cnt  <= '0;
                        if (divisor == '0) begin
                            r_quo       <= '1;
                            r_rem       <= '0;
                            r_dz        <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_prem <= w_ge ? w_sub : w_shift[DIVISOR_W:0];
                    r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_ge};
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_state <= c_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_FIN: begin
                    // A nonzero remainder implies quotient < max, so the increment cannot wrap.
                    r_quo       <= r_dvd + w_inc;
                    r_rem       <= r_prem[DIVISOR_W-1:0];
                    r_dz        <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cluster_mean_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_cluster_mean_divider: directed bench, truncating and rounding DUTs   |
// | driven in lockstep against a scoreboard. Rev 1.0                        |
// +------------------------------------------------------------------------+
module tb_cluster_mean_divider;

    localparam int DW = 20;
    localparam int VW = 12;

    logic          clk = 1'b0;
    logic          sclr, en, in_valid, out_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [DW-1:0] q0, q1;
    logic [VW-1:0] r0, r1;
    logic          dz0, dz1;

    typedef struct {
        logic [DW-1:0] q0;
        logic [DW-1:0] q1;
        logic [VW-1:0] rem;
        logic          dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cluster_mean_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .ROUND(0)) u_trunc (
        .clk(clk), .sclr(sclr), .en(en), .in_valid(in_valid), .in_ready(in_ready0),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid0), .out_ready(out_ready),
        .quotient(q0), .remainder(r0), .div_by_zero(dz0)
    );

    cluster_mean_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW), .ROUND(1)) u_round (
        .clk(clk), .sclr(sclr), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid1), .out_ready(out_ready),
        .quotient(q1), .remainder(r1), .div_by_zero(dz1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int a, input int b);
        int   n;
        exp_t e;
        int   q, r;
        n = 0;
        while (!in_ready0 && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", {31'b0, in_ready0}, 32'd1);
        dividend = DW'(a);
        divisor  = VW'(b);
        in_valid = 1'b1;
        if (b == 0) begin
            e.q0 = '1; e.q1 = '1; e.rem = '0; e.dz = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            e.q0  = DW'(q);
            e.q1  = DW'(q + ((2 * r >= b) ? 1 : 0));
            e.rem = VW'(r);
            e.dz  = 1'b0;
        end
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    task automatic wait_valid(input string tag, input int exp_lat, input int already);
        int n;
        n = already;
        while (!out_valid0 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_valid_round"}, {31'b0, out_valid1}, 32'd1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q_trunc"}, 32'(q0), 32'(e.q0));
            chk({tag, "_q_round"}, 32'(q1), 32'(e.q1));
            chk({tag, "_rem_trunc"}, 32'(r0), 32'(e.rem));
            chk({tag, "_rem_round"}, 32'(r1), 32'(e.rem));
            chk({tag, "_dz_trunc"}, {31'b0, dz0}, {31'b0, e.dz});
            chk({tag, "_dz_round"}, {31'b0, dz1}, {31'b0, e.dz});
        end
    endtask

    initial begin
        int seen;
        sclr = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0;
        tick();
        tick();
        sclr = 1'b0;

        chk("reset_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("reset_quotient", 32'(q0), 32'd0);
        chk("reset_remainder", 32'(r0), 32'd0);
        chk("reset_dz", {31'b0, dz0}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready0}, 32'd1);
        en = 1'b0;
        #1;
        chk("idle_en0_in_ready", {31'b0, in_ready0}, 32'd0);
        en = 1'b1;
        #1;

        start_op(1000, 7);
        wait_valid("d1000_7", 21, 0);
        check_result("d1000_7");
        tick();
        chk("d1000_7_valid_one_cycle", {31'b0, out_valid0}, 32'd0);

        start_op(1048575, 2);
        wait_valid("dmax_2", 21, 0);
        check_result("dmax_2");
        tick();

        start_op(1048575, 1);
        wait_valid("dmax_1", 21, 0);
        check_result("dmax_1");
        tick();

        start_op(500, 0);
        wait_valid("div0", 0, 0);
        check_result("div0");
        tick();

        start_op(12, 4);
        wait_valid("d12_4", 21, 0);
        check_result("d12_4");
        tick();

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        start_op(4095, 4095);
        wait_valid("bp", 21, 0);
        repeat (5) begin
            tick();
            chk("bp_hold_valid", {31'b0, out_valid0}, 32'd1);
            chk("bp_hold_q", 32'(q0), 32'd1);
            chk("bp_hold_rem", 32'(r0), 32'd0);
            chk("bp_hold_in_ready", {31'b0, in_ready0}, 32'd0);
        end
        out_ready = 1'b1;
        check_result("bp");
        tick();
        chk("bp_release_valid", {31'b0, out_valid0}, 32'd0);
        chk("bp_release_in_ready", {31'b0, in_ready0}, 32'd1);

        // Stall for three cycles after ten iterations.
        start_op(777777, 100);
        repeat (10) tick();
        en = 1'b0;
        repeat (3) begin
            chk("stall_in_ready", {31'b0, in_ready0}, 32'd0);
            tick();
        end
        en = 1'b1;
        wait_valid("stall", 24, 13);
        check_result("stall");
        tick();

        // Abort mid-operation with sclr.
        start_op(1000, 7);
        repeat (5) tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        sb.delete(sb.size() - 1);
        chk("abort_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("abort_q_trunc", 32'(q0), 32'd0);
        chk("abort_q_round", 32'(q1), 32'd0);
        chk("abort_rem", 32'(r0), 32'd0);
        chk("abort_in_ready", {31'b0, in_ready0}, 32'd1);
        seen = 0;
        repeat (25) begin
            tick();
            if (out_valid0 || out_valid1) seen++;
        end
        chk("abort_no_valid", seen, 32'd0);

        start_op(9, 3);
        wait_valid("d9_3", 21, 0);
        check_result("d9_3");
        tick();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
